outpkt_checksum_ivl: RTL and testbench
======================================

# outpkt_checksum_ivl

Parametrised output-packet checksum inserter for the packet-communication output path. It passes a 16-bit word stream through and inserts a 32-bit inverted additive checksum (two words) after the packet header, after every configurable interval of data bytes, and after the last data word. It sits between the output packet builder and the output FIFO/USB path, with 1-word FWFT handshakes on both sides.

## Interface
- PKT_HEADER_LEN, 10: header length in bytes; even, ≥4.
- CHECKSUM_INTERVAL, 448: data bytes between intermediate checksums; even; 0 disables intermediate checksums.
- CLK  in  1  clock; all logic on rising edge.
- RESET_N  in  1  reset; one clock, synchronous, active-low.
- din  in  16  input word.
- pkt_new  in  1  marks first header word of a packet.
- pkt_end  in  1  marks last data word of a packet.
- wr_en  in  1  write din; honoured only when full=0.
- full  out  1  input register cannot accept a word this cycle.
- dout  out  16  output word; valid while empty=0.
- pkt_end_out  out  1  qualifies dout: high on the final checksum word of a packet.
- rd_en  in  1  consume dout; ignored while empty=1.
- empty  out  1  output register holds no word.
- err  out  1  sticky protocol error; cleared only by reset.

## Operation
- Reset values: full=0, empty=1, dout=0, pkt_end_out=0, err=0; state INPUT, section HEADER, accumulator/pair/counters 0.
- States: INPUT (pass words), FOLD (add pending odd word), CK_LO, CK_HI (emit checksum words).
- Accumulation: words paired in arrival order, first = low half, second = high half; {second,first} added to 32-bit accumulator mod 2^32. pkt_new always starts a new pair.
- Checksum boundary in INPUT after forwarding a word when: section HEADER and header word count = PKT_HEADER_LEN/2; or section DATA and pkt_end; or section DATA, CHECKSUM_INTERVAL≠0 and interval word count = CHECKSUM_INTERVAL/2.
- At boundary: pending unpaired word → FOLD (adds it zero-extended, 1 cycle) → CK_LO; else → CK_LO directly.
- CK_LO emits ~acc[15:0]; CK_HI emits ~acc[31:16], then clears accumulator, pair flag and section counter and returns to INPUT.
- Section transitions after CK_HI: HEADER→DATA; DATA boundary with pkt_end→HEADER and pkt_end_out=1 on the CK_HI word; intermediate interval boundary stays DATA.
- pkt_end coinciding with an interval boundary: one checksum only, with pkt_end_out.
- err set: pkt_new on a word not at section HEADER count 0; a HEADER word 0 without pkt_new; pkt_end inside HEADER. Data still forwarded, counters follow the rules above.

## Timing
- Input: word with wr_en & ~full at edge t lands in input register; forwarded to dout at edge t+1 earliest (empty=0 after t+1).
- full deasserted combinationally when the input register is being drained the same cycle (state INPUT and output register free or being read): sustained 1 word/cycle.
- full=1 in FOLD, CK_LO, CK_HI when input register occupied.
- Output register load allowed when empty=1 or rd_en=1; rd_en with load same cycle keeps empty=0.
- Checksum overhead: 2 output cycles, +1 for FOLD on odd word count.
- Reset mid-operation: all buffered words, partial sums and pending checksums discarded; next packet must begin with pkt_new.

## Structure
- Shared package: state encoding, section encoding, checksum width (32), default header length/interval, MSB-width helper for counters (sized from max(PKT_HEADER_LEN, CHECKSUM_INTERVAL)/2).
- One sub-module: pkt_word_reg, a 1-deep register with full/empty handshake, instanced for input (with pkt_new/pkt_end sideband) and output (with pkt_end_out sideband).

## Test plan
- Header 0x0001..0x0005 with pkt_new on first, rd_en=1 → dout 0001..0005, FOLD used, then 0xFFF6, 0xFFF9; pkt_end_out=0.
- Following data 0xFFFF,0xFFFF, pkt_end on second → dout FFFF,FFFF,0x0000,0x0000; pkt_end_out=1 on last only.
- CHECKSUM_INTERVAL=8, 5-word header, 10 data words → checksums after data words 4, 8, 10; 23 output words total; pkt_end_out once.
- CHECKSUM_INTERVAL=8, pkt_end on 4th data word → exactly one data checksum, with pkt_end_out.
- rd_en low 20 cycles during stream → full high after 2 words accepted, no loss/duplication; rd_en high thereafter → 1 word/cycle outside checksum slots.
- RESET_N low for 1 cycle during CK_LO → empty=1, full=0, err=0 next cycle; next packet checksums correct. Data word without pkt_new after reset → err=1.

Source files
------------

// File: rtl/outpkt_checksum_ivl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : outpkt_checksum_ivl_pkg
// Description : Shared encodings, widths and helpers for the output-packet
//               checksum inserter.
// Revision    : 1.0 - initial release
// ============================================================================
package outpkt_checksum_ivl_pkg;

    localparam int C_WORD_W          = 16;
    localparam int C_CK_W            = 32;
    localparam int C_DEF_HDR_LEN     = 10;
    localparam int C_DEF_CK_INTERVAL = 448;

    // Main FSM encoding
    localparam logic [1:0] S_INPUT = 2'd0;   // pass words through
    localparam logic [1:0] S_FOLD  = 2'd1;   // add pending odd word
    localparam logic [1:0] S_CK_LO = 2'd2;   // emit ~acc[15:0]
    localparam logic [1:0] S_CK_HI = 2'd3;   // emit ~acc[31:16]

    typedef enum logic {
        SEC_HEADER = 1'b0,
        SEC_DATA   = 1'b1
    } sec_t;

    // Counter width able to hold max(header, interval)/2 words
    function automatic int cnt_width(input int hdr_len, input int interval);
        int max_words;
        max_words = ((hdr_len > interval) ? hdr_len : interval) / 2;
        return (max_words < 1) ? 1 : $clog2(max_words + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/outpkt_checksum_ivl_if.sv
`default_nettype none
// ============================================================================
// Module      : outpkt_checksum_ivl_if
// Description : Word-stream handshake bundle of the checksum inserter: input
//               FWFT write side, output FWFT read side and error flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface outpkt_checksum_ivl_if;
    import outpkt_checksum_ivl_pkg::*;

    logic [C_WORD_W-1:0] din;
    logic                pkt_new;
    logic                pkt_end;
    logic                wr_en;
    logic                full;
    logic [C_WORD_W-1:0] dout;
    logic                pkt_end_out;
    logic                rd_en;
    logic                empty;
    logic                err;

    modport master (
        output din, pkt_new, pkt_end, wr_en, rd_en,
        input  full, dout, pkt_end_out, empty, err
    );

    modport slave (
        input  din, pkt_new, pkt_end, wr_en, rd_en,
        output full, dout, pkt_end_out, empty, err
    );

endinterface
`default_nettype wire

// File: rtl/outpkt_checksum_ivl_pkt_word_reg.sv
`default_nettype none
// ============================================================================
// Module      : pkt_word_reg
// Description : One-deep word register with valid flag. A load wins over an
//               unload in the same cycle, so a read-plus-write stays full.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_word_reg
    import outpkt_checksum_ivl_pkg::*;
#(
    parameter int WIDTH = C_WORD_W + 1
) (
    input  wire logic             CLK,
    input  wire logic             RESET_N,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_unload,
    output logic      [WIDTH-1:0] o_data,
    output logic                  o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Capture a word on load, drop the valid flag when it is consumed
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_unload) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/outpkt_checksum_ivl.sv
`default_nettype none
// ============================================================================
// Module      : outpkt_checksum_ivl
// Description : Passes a 16-bit packet word stream through and inserts a
//               32-bit inverted additive checksum after the header, after
//               every CHECKSUM_INTERVAL data bytes and after the last word.
// Revision    : 1.0 - initial release
// ============================================================================
module outpkt_checksum_ivl
    import outpkt_checksum_ivl_pkg::*;
#(
    parameter int PKT_HEADER_LEN    = C_DEF_HDR_LEN,
    parameter int CHECKSUM_INTERVAL = C_DEF_CK_INTERVAL
) (
    input  wire logic             CLK,
    input  wire logic             RESET_N,
    outpkt_checksum_ivl_if.slave  bus
);

    localparam int                 C_CNT_W     = cnt_width(PKT_HEADER_LEN, CHECKSUM_INTERVAL);
    localparam logic [C_CNT_W-1:0] C_HDR_WORDS = C_CNT_W'(PKT_HEADER_LEN / 2);
    localparam logic [C_CNT_W-1:0] C_INT_WORDS = C_CNT_W'(CHECKSUM_INTERVAL / 2);
    localparam int                 C_IN_W      = C_WORD_W + 2;
    localparam int                 C_OUT_W     = C_WORD_W + 1;

    logic [1:0]          r_state;
    sec_t                r_sec;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [C_CK_W-1:0]   r_acc;
    logic [C_WORD_W-1:0] r_lo;
    logic                r_pair;
    logic                r_last;
    logic                r_err;

    logic [C_IN_W-1:0]   w_in_q;
    logic                w_in_valid;
    logic                w_in_load;
    logic [C_WORD_W-1:0] w_in_word;
    logic                w_in_new;
    logic                w_in_end;
    logic [C_OUT_W-1:0]  w_out_q;
    logic                w_out_valid;
    logic                w_out_free;
    logic                w_out_load;
    logic [C_OUT_W-1:0]  w_out_data;
    logic                w_fwd;
    logic                w_full;
    logic [C_CNT_W-1:0]  w_cnt_nxt;
    logic                w_bnd;
    logic                w_word_err;

    assign w_in_word = w_in_q[C_WORD_W-1:0];
    assign w_in_end  = w_in_q[C_WORD_W];
    assign w_in_new  = w_in_q[C_WORD_W+1];

    // Output register can take a word when empty or being read this cycle
    assign w_out_free = !w_out_valid || bus.rd_en;
    assign w_fwd      = (r_state == S_INPUT) && w_in_valid && w_out_free;
    assign w_full     = w_in_valid && !((r_state == S_INPUT) && w_out_free);
    assign w_in_load  = bus.wr_en && !w_full;

    assign w_cnt_nxt  = r_cnt + C_CNT_W'(1);

    // Boundary after the word currently being forwarded
    assign w_bnd = (r_sec == SEC_HEADER) ? (w_cnt_nxt == C_HDR_WORDS)
                 : (w_in_end || ((CHECKSUM_INTERVAL != 0) && (w_cnt_nxt == C_INT_WORDS)));

    // Framing violations on the forwarded word
    assign w_word_err = (r_sec == SEC_HEADER)
                      ? ((w_in_new != (r_cnt == '0)) || w_in_end)
                      : w_in_new;

    pkt_word_reg #(.WIDTH(C_IN_W)) u_in_reg (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .i_load   (w_in_load),
        .i_data   ({bus.pkt_new, bus.pkt_end, bus.din}),
        .i_unload (w_fwd),
        .o_data   (w_in_q),
        .o_valid  (w_in_valid)
    );

    // Select what the output register receives: passthrough or checksum half
    always_comb begin
        w_out_load = 1'b0;
        w_out_data = '0;
        case (r_state)
            S_INPUT: begin
                w_out_load = w_fwd;
                w_out_data = {1'b0, w_in_word};
            end
            S_CK_LO: begin
                w_out_load = w_out_free;
                w_out_data = {1'b0, ~r_acc[C_WORD_W-1:0]};
            end
            S_CK_HI: begin
                w_out_load = w_out_free;
                w_out_data = {r_last, ~r_acc[C_CK_W-1:C_WORD_W]};
            end
            default: begin
                w_out_load = 1'b0;
                w_out_data = '0;
            end
        endcase
    end

    pkt_word_reg #(.WIDTH(C_OUT_W)) u_out_reg (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .i_load   (w_out_load),
        .i_data   (w_out_data),
        .i_unload (bus.rd_en),
        .o_data   (w_out_q),
        .o_valid  (w_out_valid)
    );

    // Sequencer: pair/accumulate forwarded words, detect boundaries, emit checksum
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state <= S_INPUT;
            r_sec   <= SEC_HEADER;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_lo    <= '0;
            r_pair  <= 1'b0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_INPUT: begin
                    if (w_fwd) begin
                        if (w_word_err) begin
                            r_err <= 1'b1;
                        end
                        // pkt_new always opens a fresh pair
                        if (r_pair && !w_in_new) begin
                            r_acc  <= r_acc + {w_in_word, r_lo};
                            r_pair <= 1'b0;
                        end else begin
                            r_lo   <= w_in_word;
                            r_pair <= 1'b1;
                        end
                        r_cnt <= w_cnt_nxt;
                        if (w_bnd) begin
                            r_last  <= (r_sec == SEC_DATA) && w_in_end;
                            r_state <= (w_in_new || !r_pair) ? S_FOLD : S_CK_LO;
                        end
                    end
                end
                S_FOLD: begin
                    r_acc   <= r_acc + {{(C_CK_W-C_WORD_W){1'b0}}, r_lo};
                    r_pair  <= 1'b0;
                    r_state <= S_CK_LO;
                end
                S_CK_LO: begin
                    if (w_out_free) begin
                        r_state <= S_CK_HI;
                    end
                end
                S_CK_HI: begin
                    if (w_out_free) begin
                        r_acc   <= '0;
                        r_pair  <= 1'b0;
                        r_cnt   <= '0;
                        r_last  <= 1'b0;
                        r_sec   <= (r_sec == SEC_HEADER) ? SEC_DATA
                                 : (r_last ? SEC_HEADER : SEC_DATA);
                        r_state <= S_INPUT;
                    end
                end
                default: begin
                    r_state <= S_INPUT;
                end
            endcase
        end
    end

    assign bus.full        = w_full;
    assign bus.dout        = w_out_q[C_WORD_W-1:0];
    assign bus.pkt_end_out = w_out_q[C_WORD_W];
    assign bus.empty       = !w_out_valid;
    assign bus.err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_outpkt_checksum_ivl.sv
`default_nettype none
// ============================================================================
// Module      : tb_outpkt_checksum_ivl
// Description : Directed bench for outpkt_checksum_ivl (10-byte header,
//               8-byte checksum interval).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_outpkt_checksum_ivl;

    typedef struct {
        int          pid;
        logic [15:0] din;
        logic        nw;
        logic        en;
    } in_t;

    typedef struct {
        int          pid;
        logic [15:0] dout;
        logic        peo;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    in_t  stim[$];
    exp_t expv[$];

    outpkt_checksum_ivl_if bus();

    outpkt_checksum_ivl #(
        .PKT_HEADER_LEN    (10),
        .CHECKSUM_INTERVAL (8)
    ) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void ai(input int pid, input logic [15:0] d, input logic nw, input logic en);
        in_t r;
        r.pid = pid; r.din = d; r.nw = nw; r.en = en;
        stim.push_back(r);
    endfunction

    function automatic void ae(input int pid, input logic [15:0] d, input logic peo);
        exp_t r;
        r.pid = pid; r.dout = d; r.peo = peo;
        expv.push_back(r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic step(input logic rstn, input logic wr, input logic [15:0] d,
                        input logic nw, input logic en, input logic rd,
                        output logic acc, output logic rdok, output logic [16:0] q,
                        output logic full_s);
        @(negedge clk);
        rst_n       = rstn;
        bus.wr_en   = wr;
        bus.din     = d;
        bus.pkt_new = nw;
        bus.pkt_end = en;
        bus.rd_en   = rd;
        #1;
        full_s = bus.full;
        acc    = wr && !bus.full;
        rdok   = rd && !bus.empty;
        q      = {bus.pkt_end_out, bus.dout};
        @(posedge clk);
    endtask

    task automatic run_pkt(input int pid, input int stall_len, input int req_span);
        in_t         ins[$];
        exp_t        exs[$];
        in_t         cur;
        int          ii, oi, first, last, done_cnt;
        logic        acc, rdok, full_s;
        logic [16:0] q;
        ii = 0; oi = 0; first = -1; last = -1; done_cnt = 0;
        foreach (stim[k]) if (stim[k].pid == pid) ins.push_back(stim[k]);
        foreach (expv[k]) if (expv[k].pid == pid) exs.push_back(expv[k]);
        for (int cyc = 0; cyc < 400 && done_cnt < 6; cyc++) begin
            if (ii < ins.size()) cur = ins[ii];
            else begin
                cur.pid = pid; cur.din = 16'h0; cur.nw = 1'b0; cur.en = 1'b0;
            end
            step(1'b1, ii < ins.size(), cur.din, cur.nw, cur.en, cyc >= stall_len,
                 acc, rdok, q, full_s);
            if (stall_len > 0 && cyc == stall_len - 1) begin
                check($sformatf("pkt%0d_stall_full", pid), {31'b0, full_s}, 32'd1);
                check($sformatf("pkt%0d_stall_accepted", pid), ii, 32'd2);
            end
            if (acc) ii++;
            if (rdok) begin
                if (oi < exs.size())
                    check($sformatf("pkt%0d_word%0d", pid, oi), {15'b0, q},
                          {15'b0, exs[oi].peo, exs[oi].dout});
                if (first < 0) first = cyc;
                last = cyc;
                oi++;
            end
            if (ii == ins.size() && oi >= exs.size()) done_cnt++;
        end
        check($sformatf("pkt%0d_word_count", pid), oi, exs.size());
        if (req_span > 0) check($sformatf("pkt%0d_read_span", pid), last - first, req_span);
    endtask

    initial begin
        logic        acc, rdok, full_s;
        logic [16:0] q;
        int          rk;

        n_pass = 0; n_total = 0;

        // pkt 0: header 1..5, data FFFF FFFF
        for (int i = 1; i <= 5; i++) ai(0, 16'(i), i == 1, 1'b0);
        ai(0, 16'hFFFF, 1'b0, 1'b0);
        ai(0, 16'hFFFF, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) ae(0, 16'(i), 1'b0);
        ae(0, 16'hFFF6, 1'b0); ae(0, 16'hFFF9, 1'b0);
        ae(0, 16'hFFFF, 1'b0); ae(0, 16'hFFFF, 1'b0);
        ae(0, 16'h0000, 1'b0); ae(0, 16'h0000, 1'b1);

        // pkt 1: header 1000..5000, 10 data words 1..10, checksums after 4, 8, 10
        for (int i = 1; i <= 5; i++) ai(1, 16'(i * 16'h1000), i == 1, 1'b0);
        for (int i = 1; i <= 10; i++) ai(1, 16'(i), 1'b0, i == 10);
        for (int i = 1; i <= 5; i++) ae(1, 16'(i * 16'h1000), 1'b0);
        ae(1, 16'h6FFF, 1'b0); ae(1, 16'h9FFF, 1'b0);
        for (int i = 1; i <= 4; i++) ae(1, 16'(i), 1'b0);
        ae(1, 16'hFFFB, 1'b0); ae(1, 16'hFFF9, 1'b0);
        for (int i = 5; i <= 8; i++) ae(1, 16'(i), 1'b0);
        ae(1, 16'hFFF3, 1'b0); ae(1, 16'hFFF1, 1'b0);
        ae(1, 16'h0009, 1'b0); ae(1, 16'h000A, 1'b0);
        ae(1, 16'hFFF6, 1'b0); ae(1, 16'hFFF5, 1'b1);

        // pkt 2: pkt_end on 4th data word (coincides with interval), carry into high half
        for (int i = 1; i <= 5; i++) ai(2, 16'(i), i == 1, 1'b0);
        ai(2, 16'hFFFF, 1'b0, 1'b0); ai(2, 16'h0000, 1'b0, 1'b0);
        ai(2, 16'h0001, 1'b0, 1'b0); ai(2, 16'h0000, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) ae(2, 16'(i), 1'b0);
        ae(2, 16'hFFF6, 1'b0); ae(2, 16'hFFF9, 1'b0);
        ae(2, 16'hFFFF, 1'b0); ae(2, 16'h0000, 1'b0);
        ae(2, 16'h0001, 1'b0); ae(2, 16'h0000, 1'b0);
        ae(2, 16'hFFFF, 1'b0); ae(2, 16'hFFFE, 1'b1);

        // pkt 3: odd data count, read side stalled for 20 cycles
        for (int i = 1; i <= 5; i++) ai(3, 16'(i * 16), i == 1, 1'b0);
        ai(3, 16'h0100, 1'b0, 1'b0); ai(3, 16'h0200, 1'b0, 1'b0); ai(3, 16'h0300, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) ae(3, 16'(i * 16), 1'b0);
        ae(3, 16'hFF6F, 1'b0); ae(3, 16'hFF9F, 1'b0);
        ae(3, 16'h0100, 1'b0); ae(3, 16'h0200, 1'b0); ae(3, 16'h0300, 1'b0);
        ae(3, 16'hFBFF, 1'b0); ae(3, 16'hFDFF, 1'b1);

        rst_n = 1'b0;
        bus.din = '0; bus.pkt_new = 1'b0; bus.pkt_end = 1'b0;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_full",  {31'b0, bus.full},        32'd0);
        check("reset_empty", {31'b0, bus.empty},       32'd1);
        check("reset_dout",  {16'b0, bus.dout},        32'd0);
        check("reset_peo",   {31'b0, bus.pkt_end_out}, 32'd0);
        check("reset_err",   {31'b0, bus.err},         32'd0);

        run_pkt(0, 0, 11);
        run_pkt(1, 0, 0);
        run_pkt(2, 0, 0);
        run_pkt(3, 20, 0);
        @(negedge clk); #1;
        check("err_after_good_pkts", {31'b0, bus.err}, 32'd0);

        // Header then reset while the header checksum low word is pending
        rk = 0;
        for (int c = 0; c < 7; c++) begin
            step(1'b1, c < 5, 16'(c + 1), c == 0, 1'b0, 1'b1, acc, rdok, q, full_s);
            if (rdok) begin
                check($sformatf("rst_hdr_word%0d", rk), {15'b0, q}, 32'(rk + 1));
                rk++;
            end
        end
        check("rst_hdr_count", rk, 32'd5);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, acc, rdok, q, full_s);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_empty", {31'b0, bus.empty}, 32'd1);
        check("midrst_full",  {31'b0, bus.full},  32'd0);
        check("midrst_err",   {31'b0, bus.err},   32'd0);
        run_pkt(0, 0, 11);

        // Word without pkt_new straight after reset
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, acc, rdok, q, full_s);
        step(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, acc, rdok, q, full_s);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, acc, rdok, q, full_s);
        @(negedge clk); #1;
        check("err_missing_pkt_new", {31'b0, bus.err}, 32'd1);

        // pkt_end on a header word
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, acc, rdok, q, full_s);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, acc, rdok, q, full_s);
        @(negedge clk); #1;
        check("err_cleared_by_reset", {31'b0, bus.err}, 32'd0);
        step(1'b1, 1'b1, 16'hABCD, 1'b1, 1'b1, 1'b1, acc, rdok, q, full_s);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, acc, rdok, q, full_s);
        @(negedge clk); #1;
        check("err_pkt_end_in_header", {31'b0, bus.err}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
